// File: rtl/nixie_tube_monitor_if.sv
// Segment/select bus seen by the monitor, plus the decoded results it reports.
interface nixie_tube_monitor_if;
    logic [6:0] i_nixieTube;
    logic       i_sel;
    logic [3:0] o_digit0;
    logic [3:0] o_digit1;
    logic       o_valid0;
    logic       o_valid1;
    logic       o_update;
    logic       o_error;

    modport master (
        output i_nixieTube, i_sel,
        input  o_digit0, o_digit1, o_valid0, o_valid1, o_update, o_error
    );

    modport slave (
        input  i_nixieTube, i_sel,
        output o_digit0, o_digit1, o_valid0, o_valid1, o_update, o_error
    );
endinterface

// File: rtl/nixie_tube_monitor.sv
// Receive-side decoder for a two-digit multiplexed 7-segment bus: synchronizes,
// qualifies each pattern for stability and decodes it to per-digit hex values.
module nixie_tube_monitor #(
    parameter int STABLE_CYCLES   = 16,
    parameter bit SEG_ACTIVE_HIGH = 1'b1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    nixie_tube_monitor_if.slave bus
);
    localparam int             CW      = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0]  CNT_CMT = CW'(STABLE_CYCLES - 1);

    logic [7:0]      sync1_q, sync2_q, prev_q, s;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0][3:0] digit_q, digit_d;
    logic [1:0]      valid_q, valid_d;
    logic            upd_q, upd_d, err_q, err_d;
    logic            commit, idx;
    logic [4:0]      dec;

    // {hit, value}; hit=0 covers both blank and undecodable patterns
    function automatic logic [4:0] seg_decode(input logic [6:0] p);
        case (p)
            7'h3F:   seg_decode = {1'b1, 4'h0};
            7'h06:   seg_decode = {1'b1, 4'h1};
            7'h5B:   seg_decode = {1'b1, 4'h2};
            7'h4F:   seg_decode = {1'b1, 4'h3};
            7'h66:   seg_decode = {1'b1, 4'h4};
            7'h6D:   seg_decode = {1'b1, 4'h5};
            7'h7D:   seg_decode = {1'b1, 4'h6};
            7'h07:   seg_decode = {1'b1, 4'h7};
            7'h7F:   seg_decode = {1'b1, 4'h8};
            7'h6F:   seg_decode = {1'b1, 4'h9};
            7'h77:   seg_decode = {1'b1, 4'hA};
            7'h7C:   seg_decode = {1'b1, 4'hB};
            7'h39:   seg_decode = {1'b1, 4'hC};
            7'h5E:   seg_decode = {1'b1, 4'hD};
            7'h79:   seg_decode = {1'b1, 4'hE};
            7'h71:   seg_decode = {1'b1, 4'hF};
            default: seg_decode = 5'h00;
        endcase
    endfunction

    // Select line is never inverted, only the segments
    assign s      = SEG_ACTIVE_HIGH ? sync2_q : {sync2_q[7], ~sync2_q[6:0]};
    assign commit = (s == prev_q) && (cnt_q == CNT_CMT);
    assign idx    = s[7];
    assign dec    = seg_decode(s[6:0]);

    always_comb begin
        cnt_d   = cnt_q;
        digit_d = digit_q;
        valid_d = valid_q;
        upd_d   = 1'b0;
        err_d   = 1'b0;
        if (s != prev_q)
            cnt_d = '0;
        else if (cnt_q < CNT_MAX)
            cnt_d = cnt_q + 1'b1;
        if (commit) begin
            if (dec[4]) begin
                upd_d        = !valid_q[idx] || (digit_q[idx] != dec[3:0]);
                digit_d[idx] = dec[3:0];
                valid_d[idx] = 1'b1;
            end else begin
                upd_d        = valid_q[idx];
                err_d        = (s[6:0] != 7'h00);
                valid_d[idx] = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            cnt_q   <= '0;
            digit_q <= '0;
            valid_q <= '0;
            upd_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync1_q <= {bus.i_sel, bus.i_nixieTube};
            sync2_q <= sync1_q;
            prev_q  <= s;
            cnt_q   <= cnt_d;
            digit_q <= digit_d;
            valid_q <= valid_d;
            upd_q   <= upd_d;
            err_q   <= err_d;
        end
    end

    assign bus.o_digit0 = digit_q[0];
    assign bus.o_digit1 = digit_q[1];
    assign bus.o_valid0 = valid_q[0];
    assign bus.o_valid1 = valid_q[1];
    assign bus.o_update = upd_q;
    assign bus.o_error  = err_q;
endmodule

// File: doc/nixie_tube_monitor.md
# nixie_tube_monitor

Receive-side decoder for the two-digit multiplexed 7-segment Pmod bus: it samples the segment lines and digit-select line, qualifies each pattern for stability, and decodes it back to two hex digit values with per-digit valid flags. It sits on the far end of the display interface. It is used for loopback self-test, where the display driver's outputs are routed back into the FPGA, and for checking an external board that drives the same bus. Results are presented as registered values plus single-cycle update and error strobes.

## Interface
- STABLE_CYCLES, 16, consecutive identical samples required before a pattern is committed; legal range 2..65535.
- SEG_ACTIVE_HIGH, 1, 1 means a segment is lit when its line is 1; 0 inverts all seven lines before decoding. i_sel is never inverted.
- i_clk  input  1  system clock; single clock domain.
- i_rst  input  1  reset; asynchronous, active-high.
- i_nixieTube  input  7  segment lines: bit0=a, bit1=b, …, bit6=g. Asynchronous to i_clk.
- i_sel  input  1  digit select: 0 = digit0, 1 = digit1. Asynchronous to i_clk.
- o_digit0  output  4  last committed hex value of digit0.
- o_digit1  output  4  last committed hex value of digit1.
- o_valid0  output  1  digit0 holds a decoded value; 0 when blank or invalid.
- o_valid1  output  1  digit1 holds a decoded value; 0 when blank or invalid.
- o_update  output  1  one-cycle pulse when a digit's value or valid flag changes.
- o_error  output  1  one-cycle pulse when a stable pattern is not decodable.

## Operation
- **Input synchronization.** A two-flop synchronizer captures all 8 input bits {i_sel, i_nixieTube}, followed by polarity normalization. The result is `s`.
- **Stability tracking.**
  - `prev` holds the previous `s`. Counter width is $clog2(STABLE_CYCLES+1).
  - If `s != prev`: cnt <= 0.
  - If `s == prev` and cnt < STABLE_CYCLES: cnt <= cnt+1.
  - At cnt == STABLE_CYCLES: cnt holds (saturates).
  - A commit fires exactly once per stable run, on the cycle where `s == prev` and cnt == STABLE_CYCLES-1.
- **Decode table (gfedcba):**
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- **Commit actions.** The target digit is selected by the committed sel bit.
  - **Table match:** digit <= value, valid <= 1. o_update pulses if the value differs from the held one or valid was 0.
  - **Pattern 00 (blank):** valid <= 0, digit value held. o_update pulses if valid was 1. No error.
  - **Any other pattern:** valid <= 0, digit value held, o_error pulses. o_update also pulses if valid was 1. o_error and o_update may assert in the same cycle.
- The non-selected digit is never modified by a commit.
- **Multiplex flicker:** a run shorter than STABLE_CYCLES, including a ghost pattern during a sel transition, never commits and produces no strobes.

## Timing
- **Reset state:**
  - o_digit0 = o_digit1 = 0, o_valid0 = o_valid1 = 0, o_update = o_error = 0.
  - Synchronizer, `prev` and cnt are all 0.
  - Reset asserted mid-run discards the partial count. No strobe is generated by the reset itself.
- **First run after reset:** the idle pattern (sel=0, segs=00) reaches its count and commits as blank on digit0. No strobes, because valid is already 0.
- **Latency:** the input changes and then holds. Outputs and strobes update on the rising edge STABLE_CYCLES+3 edges after the first edge that samples the new value: 2 synchronizer edges, 1 `prev` edge, then STABLE_CYCLES-1 counting edges, then the commit edge.
- **Strobes:** o_update and o_error are registered and high for exactly one cycle per commit.
- **Back-to-back runs:** commits are spaced at least STABLE_CYCLES+1 cycles apart.
- **Saturated count:** a continuously held pattern produces exactly one commit. After that the counter stays at STABLE_CYCLES with no further strobes until the input changes.

## Test plan
- **Decode and latency:** reset, then drive sel=0, segs=0x5B held, with STABLE_CYCLES=16. Require o_digit0=2, o_valid0=1 and one o_update pulse exactly 19 edges after the first sampling edge. o_digit1 and o_valid1 stay 0.
- **Multiplexed operation:** alternate sel=0/segs=0x06 and sel=1/segs=0x71, each held 40 cycles, for 4 periods. Require o_digit0=1, o_digit1=F and both valid. Exactly two o_update pulses total.
- **Glitch rejection:** with a stable 0x3F on digit1, insert a 10-cycle 0x7F pulse. Require no strobe and o_digit1 unchanged at 0.
- **Invalid pattern:** digit0 holds 7 and is valid; drive 0x01 stable. Require one cycle with o_error=1 and o_update=1, o_valid0=0, o_digit0 still 7.
- **Blank and inverted polarity:** with SEG_ACTIVE_HIGH=0, drive raw 0x7F (blank) on digit0 after a valid 5 (raw 0x12). Require o_valid0 falls with one o_update and no o_error.
- **Async reset mid-run:** pulse i_rst at cnt=8 while 0x4F is held. Require all outputs 0 immediately. After release, 0x4F commits 19 edges later as 3.
